// File: rtl/i2c_master_writer_pkg.sv
// Shared definitions for the I2C master blocks: FSM state encoding and the
// number of SCL quarter-periods spent in each bus phase.
package i2c_master_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RESTART = 3'd2,
    S_BIT     = 3'd3,
    S_ACK     = 3'd4,
    S_STOP    = 3'd5,
    S_FREE    = 3'd6,
    S_HOLD    = 3'd7
  } state_t;

  localparam int DATA_W    = 8;
  localparam int START_Q   = 2;
  localparam int RESTART_Q = 2;
  localparam int BIT_Q     = 4;
  localparam int ACK_Q     = 4;
  localparam int STOP_Q    = 3;
  localparam int FREE_Q    = 2;

  // True when quarter index q is the final quarter of phase s.
  function automatic logic is_last_quarter(input state_t s, input logic [1:0] q);
    int n;
    n = 1;
    case (s)
      S_START:   n = START_Q;
      S_RESTART: n = RESTART_Q;
      S_BIT:     n = BIT_Q;
      S_ACK:     n = ACK_Q;
      S_STOP:    n = STOP_Q;
      S_FREE:    n = FREE_Q;
      default:   n = 1;
    endcase
    return (int'(q) == n - 1);
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period divider: restartable counter that ticks on the last
// clk cycle of every CLK_DIV-cycle quarter.
module i2c_quarter_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    if (restart_i || (cnt_q == LAST)) cnt_d = '0;
    else                              cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/i2c_master_writer.sv
// Write-only I2C master: turns byte commands into start / data / ACK / stop
// sequences on a driven SCL and open-drain style SDA.
module i2c_master_writer
  import i2c_master_writer_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                scl,
  output logic                sda_out,
  input  logic                sda_in,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                done,
  output logic                nack
);

  state_t              state_q, state_d;
  logic [1:0]          qidx_q, qidx_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                stop_q, stop_d;
  logic                ack_q, ack_d;
  logic                nack_q, nack_d;
  logic                done_q, done_d;
  logic                scl_q, scl_d;
  logic                sda_q, sda_d;
  logic                accept, tick, last;

  assign accept = cmd_valid && cmd_ready;
  assign last   = is_last_quarter(state_q, qidx_q);

  i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart_i (accept),
    .tick_o    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      qidx_q   <= '0;
      bitcnt_q <= '0;
      stop_q   <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      qidx_q   <= qidx_d;
      bitcnt_q <= bitcnt_d;
      stop_q   <= stop_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
    end
    shift_q <= shift_d;
  end

  always_comb begin
    state_d  = state_q;
    qidx_d   = qidx_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    stop_d   = stop_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          shift_d  = cmd_data;
          stop_d   = cmd_stop;
          bitcnt_d = '0;
          qidx_d   = '0;
          // A start is mandatory whenever the bus is not already owned.
          if (state_q == S_IDLE) state_d = S_START;
          else                   state_d = cmd_start ? S_RESTART : S_BIT;
        end
      end
      default: begin
        if (tick && (state_q == S_ACK) && (qidx_q == 2'd2)) ack_d = sda_in;
        if (tick) begin
          if (!last) begin
            qidx_d = qidx_q + 2'd1;
          end else begin
            qidx_d = '0;
            case (state_q)
              S_RESTART: state_d = S_START;
              S_START:   state_d = S_BIT;
              S_BIT: begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                if (bitcnt_q == 3'd7) state_d = S_ACK;
                else                  bitcnt_d = bitcnt_q + 3'd1;
              end
              S_ACK: begin
                done_d  = 1'b1;
                nack_d  = ack_q;
                state_d = (ack_q || stop_q) ? S_STOP : S_HOLD;
              end
              S_STOP:  state_d = S_FREE;
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Line levels are derived from the upcoming phase so they register on the
  // first cycle of each quarter.
  always_comb begin
    scl_d     = 1'b1;
    sda_d     = 1'b1;
    cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
    case (state_d)
      S_HOLD:    scl_d = 1'b0;
      S_RESTART: scl_d = (qidx_d != 2'd0);
      S_START:   sda_d = 1'b0;
      S_BIT: begin
        scl_d = qidx_d[1];
        sda_d = shift_d[DATA_W-1];
      end
      S_ACK:     scl_d = qidx_d[1];
      S_STOP: begin
        scl_d = (qidx_d != 2'd0);
        sda_d = 1'b0;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  assign scl     = scl_q;
  assign sda_out = sda_q;
  assign done    = done_q;
  assign nack    = nack_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Bench for i2c_master_writer: a bus decoder / slave model feeds a scoreboard
// of expected bytes, ACK results and transaction timings.
module tb_i2c_master_writer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl, sda_out, sda_in;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic       cmd_start = 1'b0, cmd_stop = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       done, nack;
  logic       slv_sda = 1'b1;

  assign sda_in = sda_out & slv_sda;

  i2c_master_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_out   (sda_out),
    .sda_in    (sda_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_data  (cmd_data),
    .done      (done),
    .nack      (nack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       start;
    logic       stop;
    logic       nk;
    int         done_cyc;
  } exp_t;

  exp_t expq[$];
  logic ackq[$];

  int   n_vec = 0;
  int   n_err = 0;
  logic owned = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bus decoder, slave ACK driver and scoreboard.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       saw_start = 1'b0, saw_stop = 1'b0, ack_drv = 1'b0, pend = 1'b0;
  int         bitn = 0, pend_cyc = 0;
  logic [7:0] dec_byte = 8'h00, ack_byte = 8'h00;

  always @(negedge clk) begin
    logic s_scl, s_sda, a;
    exp_t e;
    s_scl = scl;
    s_sda = sda_in;
    if (reset) begin
      expq.delete();
      ackq.delete();
      saw_start = 1'b0;
      saw_stop  = 1'b0;
      pend      = 1'b0;
      bitn      = 0;
      slv_sda   = 1'b1;
    end else begin
      if (prev_scl && s_scl && prev_sda && !s_sda) begin
        saw_start = 1'b1;
        bitn      = 0;
      end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
        saw_stop = 1'b1;
      end
      if (!prev_scl && s_scl) begin
        if (bitn < 8) begin
          dec_byte = {dec_byte[6:0], s_sda};
          bitn++;
        end else begin
          ack_drv  = sda_out;
          ack_byte = dec_byte;
          bitn     = 9;
        end
      end
      if (prev_scl && !s_scl) begin
        if (bitn == 8) begin
          a = 1'b1;
          if (ackq.size() > 0) a = ackq.pop_front();
          slv_sda = !a;
        end else if (bitn == 9) begin
          slv_sda = 1'b1;
          bitn    = 0;
        end
      end

      if (done) begin
        if (expq.size() == 0) begin
          check("unexpected_done", 32'(expq.size()), 1);
        end else begin
          e = expq.pop_front();
          check("byte", ack_byte, e.data);
          check("ack_slot_sda_out", ack_drv, 1);
          check("nack", nack, e.nk);
          check("start_seen", saw_start, e.start);
          check("done_cycle", cyc, e.done_cyc);
          saw_start = 1'b0;
          if (e.stop) begin
            check("ready_low_stopping", cmd_ready, 0);
            pend     = 1'b1;
            pend_cyc = cyc + 5 * CLK_DIV;
          end else begin
            check("hold_ready", cmd_ready, 1);
            check("hold_scl_low", scl, 0);
            check("hold_no_stop", saw_stop, 0);
          end
        end
      end
      if (pend && cmd_ready) begin
        check("ready_return_cycle", cyc, pend_cyc);
        check("stop_seen", saw_stop, 1);
        saw_stop = 1'b0;
        pend     = 1'b0;
      end else if (pend && (cyc > pend_cyc + 200)) begin
        check("ready_return_timeout", cmd_ready, 1);
        pend = 1'b0;
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  // Issue one command; the model's timing is the quarter count of the
  // transaction times CLK_DIV, measured from the accepting edge.
  task automatic send(input logic [7:0] d, input logic st, input logic sp,
                      input logic nk, input logic track);
    exp_t e;
    int   w;
    int   lat_q;
    logic from_idle, found;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("ready_wait", cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_start = st;
    cmd_stop  = sp;
    from_idle = !owned;
    lat_q = from_idle ? 38 : (st ? 40 : 36);
    if (track) begin
      e.data     = d;
      e.start    = from_idle || st;
      e.stop     = sp || nk;
      e.nk       = nk;
      e.done_cyc = cyc + 1 + lat_q * CLK_DIV;
      expq.push_back(e);
      ackq.push_back(!nk);
    end
    owned = !(sp || nk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_start = 1'($urandom);
    cmd_stop  = 1'($urandom);
    if (from_idle) begin
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
        if (scl && !sda_out) found = 1'b1;
        else @(negedge clk);
      end
      check("start_after_idle", found, 1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((expq.size() != 0 || pend) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) check("drain_timeout", 32'(expq.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic st, sp, nk;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_out, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);

    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8'h90, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    // Abort a byte mid-bit with reset; nack is still 1 from the last byte.
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda_out, 1);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_nack", nack, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    owned = 1'b0;

    send(8'h42, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h17, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h90, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h91, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      st = 1'($urandom);
      sp = ($urandom_range(0, 3) == 0);
      nk = ($urandom_range(0, 4) == 0);
      send(d, st, sp, nk, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
